// File: rtl/rf_writeback_unit_pkg.sv
// Shared register-file types: data/index widths, the zero register and the writeback entry.
package risc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_unit_if.sv
// Result/issue/decode-query/register-file-write bundle around the writeback unit.
interface rf_writeback_unit_if
  import risc_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic              res_valid;
  logic              res_ready;
  logic              res_wen;
  logic [ADDR_W-1:0] res_rd;
  logic [DATA_W-1:0] res_data;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_stall;

  logic [ADDR_W-1:0] q_rs;
  logic [ADDR_W-1:0] q_rt;
  logic              busy_rs;
  logic              busy_rt;

  logic              rf_WE;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_in;

  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output res_valid, res_wen, res_rd, res_data, iss_valid, iss_rd, q_rs, q_rt,
    input  res_ready, iss_stall, busy_rs, busy_rt, rf_WE, rf_rd, rf_in, fifo_count
  );

  modport slave (
    input  res_valid, res_wen, res_rd, res_data, iss_valid, iss_rd, q_rs, q_rt,
    output res_ready, iss_stall, busy_rs, busy_rt, rf_WE, rf_rd, rf_in, fifo_count
  );

endinterface

// File: rtl/rf_writeback_unit_fifo.sv
// Generic synchronous FIFO; head is visible combinationally, push while full and pop while empty are ignored.
// Registered occupancy count; async active-high reset clears pointers and count.
module wb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 push_dat,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Buffers completed results and drains one per cycle into the register file write port (accept N -> WE after N+1).
// Keeps the per-register busy scoreboard for decode; res_ready drops only when the FIFO is full.
module rf_writeback_unit
  import risc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              resetControl,
  rf_writeback_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [NREG-1:0]  busy;
  logic             issue_set;

  assign push_entry = '{wen: bus.res_wen, rd: bus.res_rd, data: bus.res_data};

  wb_fifo #(
    .T     (wb_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (resetControl),
    .push     (bus.res_valid),
    .push_dat (push_entry),
    .pop      (!empty),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign bus.res_ready  = !full;
  assign bus.fifo_count = count;

  assign bus.iss_stall = bus.iss_valid && (bus.iss_rd != REG_ZERO) && busy[bus.iss_rd];
  assign bus.busy_rs   = (bus.q_rs != REG_ZERO) && busy[bus.q_rs];
  assign bus.busy_rt   = (bus.q_rt != REG_ZERO) && busy[bus.q_rt];
  assign issue_set     = bus.iss_valid && !bus.iss_stall && (bus.iss_rd != REG_ZERO);

  always_ff @(posedge Clk or posedge resetControl) begin
    if (resetControl) begin
      bus.rf_WE <= 1'b0;
      bus.rf_rd <= '0;
      bus.rf_in <= '0;
    end else if (!empty) begin
      bus.rf_WE <= head.wen && (head.rd != REG_ZERO);
      bus.rf_rd <= head.rd;
      bus.rf_in <= head.data;
    end else begin
      bus.rf_WE <= 1'b0;
    end
  end

  // Clear is applied on the same edge the register file commits; the later set wins on a collision.
  always_ff @(posedge Clk or posedge resetControl) begin
    if (resetControl) begin
      busy <= '0;
    end else begin
      if (bus.rf_WE)  busy[bus.rf_rd]  <= 1'b0;
      if (issue_set)  busy[bus.iss_rd] <= 1'b1;
      busy[REG_ZERO] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: inputs change and outputs are sampled on the falling clock edge.
module tb_rf_writeback_unit;

  logic Clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  rf_writeback_unit_if #(.DEPTH(4)) bus ();

  rf_writeback_unit #(.DEPTH(4)) dut (
    .Clk          (Clk),
    .resetControl (rst),
    .bus          (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic quiet();
    bus.res_valid = 1'b0;
    bus.res_wen   = 1'b0;
    bus.res_rd    = '0;
    bus.res_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic test_reset();
    quiet();
    bus.q_rs = 5'd0;
    bus.q_rt = 5'd0;
    rst = 1'b1;
    repeat (2) @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", bus.rf_WE); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
    n_cmp++; if (bus.res_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.res_ready); end
    n_cmp++; if (bus.rf_rd !== 5'd0 || bus.rf_in !== 32'd0) begin n_bad++; $display("FAIL reset_rf got=%0d/%h exp=0/0", bus.rf_rd, bus.rf_in); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge Clk);
    bus.res_valid = 1'b1; bus.res_wen = 1'b1; bus.res_rd = 5'd5; bus.res_data = 32'hDEADBEEF;
    @(negedge Clk);
    quiet();
    n_cmp++; if (bus.fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count1 got=%0d exp=1", bus.fifo_count); end
    n_cmp++; if (bus.rf_WE !== 1'b0) begin n_bad++; $display("FAIL single_we_early got=%b exp=0", bus.rf_WE); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b1) begin n_bad++; $display("FAIL single_we got=%b exp=1", bus.rf_WE); end
    n_cmp++; if (bus.rf_rd !== 5'd5) begin n_bad++; $display("FAIL single_rd got=%0d exp=5", bus.rf_rd); end
    n_cmp++; if (bus.rf_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data got=%h exp=deadbeef", bus.rf_in); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_count0 got=%0d exp=0", bus.fifo_count); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b0) begin n_bad++; $display("FAIL single_we_drop got=%b exp=0", bus.rf_WE); end
    n_cmp++; if (bus.rf_rd !== 5'd5 || bus.rf_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_hold got=%0d/%h exp=5/deadbeef", bus.rf_rd, bus.rf_in); end
  endtask

  task automatic test_scoreboard();
    @(negedge Clk);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.q_rs = 5'd7;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL sb_first_issue got=%b exp=0", bus.iss_stall); end
    @(negedge Clk);
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall got=%b exp=1", bus.iss_stall); end
    n_cmp++; if (bus.busy_rs !== 1'b1) begin n_bad++; $display("FAIL sb_busy_rs got=%b exp=1", bus.busy_rs); end
    quiet();
    bus.res_valid = 1'b1; bus.res_wen = 1'b1; bus.res_rd = 5'd7; bus.res_data = 32'h0000_0077;
    @(negedge Clk);
    quiet();
    n_cmp++; if (bus.busy_rs !== 1'b1) begin n_bad++; $display("FAIL sb_busy_queued got=%b exp=1", bus.busy_rs); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b1 || bus.rf_rd !== 5'd7) begin n_bad++; $display("FAIL sb_write got=%b/%0d exp=1/7", bus.rf_WE, bus.rf_rd); end
    n_cmp++; if (bus.busy_rs !== 1'b1) begin n_bad++; $display("FAIL sb_busy_at_we got=%b exp=1", bus.busy_rs); end
    @(negedge Clk);
    n_cmp++; if (bus.busy_rs !== 1'b0) begin n_bad++; $display("FAIL sb_busy_cleared got=%b exp=0", bus.busy_rs); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL sb_stall_dropped got=%b exp=0", bus.iss_stall); end
    @(negedge Clk);
    quiet();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      n_cmp++; if (bus.res_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.res_ready); end
      if (i >= 3) begin
        n_cmp++; if (bus.rf_WE !== 1'b1 || bus.rf_rd !== 5'(i - 2)) begin n_bad++; $display("FAIL b2b_order i=%0d got=%b/%0d exp=1/%0d", i, bus.rf_WE, bus.rf_rd, i - 2); end
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_bad++; $display("FAIL b2b_count i=%0d got=%0d exp=1", i, bus.fifo_count); end
      end
      bus.res_valid = 1'b1; bus.res_wen = 1'b1; bus.res_rd = 5'(i); bus.res_data = 32'(100 + i);
    end
    @(negedge Clk);
    quiet();
    n_cmp++; if (bus.rf_rd !== 5'd5 || bus.rf_in !== 32'd105) begin n_bad++; $display("FAIL b2b_rd5 got=%0d/%0d exp=5/105", bus.rf_rd, bus.rf_in); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b1 || bus.rf_rd !== 5'd6 || bus.rf_in !== 32'd106) begin n_bad++; $display("FAIL b2b_rd6 got=%b/%0d/%0d exp=1/6/106", bus.rf_WE, bus.rf_rd, bus.rf_in); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b0 || bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL b2b_drain got=%b/%0d exp=0/0", bus.rf_WE, bus.fifo_count); end
  endtask

  task automatic test_no_write();
    @(negedge Clk);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; bus.q_rt = 5'd3;
    @(negedge Clk);
    quiet();
    bus.res_valid = 1'b1; bus.res_wen = 1'b1; bus.res_rd = 5'd0; bus.res_data = 32'hFFFFFFFF;
    @(negedge Clk);
    n_cmp++; if (bus.busy_rt !== 1'b1) begin n_bad++; $display("FAIL nw_busy_set got=%b exp=1", bus.busy_rt); end
    bus.res_wen = 1'b0; bus.res_rd = 5'd3; bus.res_data = 32'h0000_0033;
    @(negedge Clk);
    quiet();
    n_cmp++; if (bus.rf_WE !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_in !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL nw_rd0 got=%b/%0d/%h exp=0/0/ffffffff", bus.rf_WE, bus.rf_rd, bus.rf_in); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b0 || bus.rf_rd !== 5'd3 || bus.rf_in !== 32'h33) begin n_bad++; $display("FAIL nw_wen0 got=%b/%0d/%h exp=0/3/33", bus.rf_WE, bus.rf_rd, bus.rf_in); end
    @(negedge Clk);
    n_cmp++; if (bus.busy_rt !== 1'b1) begin n_bad++; $display("FAIL nw_busy_kept got=%b exp=1", bus.busy_rt); end
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.q_rs = 5'd9;
    @(negedge Clk);
    quiet();
    bus.res_valid = 1'b1; bus.res_wen = 1'b1; bus.res_rd = 5'd9; bus.res_data = 32'h99;
    @(negedge Clk);
    bus.res_rd = 5'd10; bus.res_data = 32'hAA;
    @(negedge Clk);
    quiet();
    n_cmp++; if (bus.rf_WE !== 1'b1 || bus.fifo_count !== 3'd1 || bus.busy_rs !== 1'b1) begin n_bad++; $display("FAIL ar_pre got=%b/%0d/%b exp=1/1/1", bus.rf_WE, bus.fifo_count, bus.busy_rs); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.rf_WE !== 1'b0) begin n_bad++; $display("FAIL ar_we got=%b exp=0", bus.rf_WE); end
    n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL ar_count got=%0d exp=0", bus.fifo_count); end
    n_cmp++; if (bus.busy_rs !== 1'b0 || bus.busy_rt !== 1'b0) begin n_bad++; $display("FAIL ar_busy got=%b/%b exp=0/0", bus.busy_rs, bus.busy_rt); end
    @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_in !== 32'd0) begin n_bad++; $display("FAIL ar_hold got=%b/%0d/%h exp=0/0/0", bus.rf_WE, bus.rf_rd, bus.rf_in); end
    rst = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++; if (bus.rf_WE !== 1'b0 || bus.rf_rd !== 5'd0 || bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL ar_stale got=%b/%0d/%0d exp=0/0/0", bus.rf_WE, bus.rf_rd, bus.fifo_count); end
  endtask

  task automatic test_zero_index();
    @(negedge Clk);
    bus.q_rs = 5'd0; bus.q_rt = 5'd0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1;
    n_cmp++; if (bus.busy_rs !== 1'b0 || bus.busy_rt !== 1'b0) begin n_bad++; $display("FAIL zero_busy got=%b/%b exp=0/0", bus.busy_rs, bus.busy_rt); end
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall got=%b exp=0", bus.iss_stall); end
    @(negedge Clk);
    n_cmp++; if (dut.busy !== 32'd0) begin n_bad++; $display("FAIL zero_vector got=%h exp=0", dut.busy); end
    n_cmp++; if (bus.iss_stall !== 1'b0 || bus.busy_rs !== 1'b0) begin n_bad++; $display("FAIL zero_after got=%b/%b exp=0/0", bus.iss_stall, bus.busy_rs); end
    quiet();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_scoreboard();
    test_back_to_back();
    test_no_write();
    test_async_reset();
    test_zero_index();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
